// File: rtl/kinematics_pkg.sv
`default_nettype none
// ============================================================================
// Package     : kinematics_pkg
// Description : Shared types and constants for the SCARA forward-kinematics
//               datapath: FSM state encoding, angle formats, CORDIC gain,
//               arctangent table and the quadrant-fold helper.
// Revision    : 1.0 - initial release
// ============================================================================
package kinematics_pkg;

  // External joint-angle width: LSB = 2*pi/8192.
  localparam int ANGLE_W = 13;
  // Internal CORDIC angle width: the 13-bit angle with 3 extra LSBs.
  localparam int ZW      = 16;

  // 0.607253 in Q0.16, pre-compensates the CORDIC gain.
  localparam logic [15:0] CORDIC_K = 16'd39797;

  localparam logic signed [ANGLE_W-1:0] HALF_PI = 13'sd2048;
  localparam logic        [ANGLE_W-1:0] PI      = 13'h1000;

  // atan(2^-i) in 16-bit angle units (full circle = 65536).
  localparam logic [ZW-1:0] ATAN_TABLE [16] = '{
    16'd8192, 16'd4836, 16'd2555, 16'd1297, 16'd651, 16'd326, 16'd163, 16'd81,
    16'd41,   16'd20,   16'd10,   16'd5,    16'd3,   16'd1,   16'd1,   16'd0
  };

  typedef enum logic [2:0] {
    ST_INIT = 3'd0,
    ST_PREP = 3'd1,
    ST_ROT1 = 3'd2,
    ST_ROT2 = 3'd3,
    ST_SUM  = 3'd4
  } fk_state_t;

  function automatic logic [ZW-1:0] atan_lut(input logic [3:0] idx);
    return ATAN_TABLE[idx];
  endfunction

  // Brings an angle into [-pi/2, +pi/2] so the CORDIC converges. Angles
  // outside that range are shifted by pi (wrapping in 13 bits) and the
  // rotation result must then be negated. Returns {negate, folded_angle}.
  function automatic logic [ANGLE_W:0] quad_fold(input logic signed [ANGLE_W-1:0] a);
    if (a > HALF_PI || a < -HALF_PI) begin
      return {1'b1, a + PI};
    end
    return {1'b0, a};
  endfunction

endpackage
`default_nettype wire

// File: rtl/forward_kinematics_cordic.sv
`default_nettype none
// ============================================================================
// Module      : cordic_rotate
// Description : Iterative rotation-mode CORDIC, one iteration per clock.
//               Rotates the vector (length*K, 0) by 'angle' and optionally
//               negates the result.
// Ports       : clk, reset        - clock, synchronous active-high reset
//               start             - load a new rotation (1 cycle)
//               length [12:0]     - unsigned vector length, position LSBs
//               angle  [15:0]     - signed folded angle, 16-bit units
//               negate            - negate both outputs
//               x, y   [DW-1:0]   - rotated vector, 2 fractional bits
//               done              - high on the edge of the final iteration
// Revision    : 1.0 - initial release
// ============================================================================
module cordic_rotate
  import kinematics_pkg::*;
#(
  parameter int ITER = 16,
  parameter int DW   = 20
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ANGLE_W-1:0]   length,
  input  logic signed [ZW-1:0] angle,
  input  logic                 negate,
  output logic signed [DW-1:0] x,
  output logic signed [DW-1:0] y,
  output logic                 done
);

  logic signed [DW-1:0] x_q, x_d;
  logic signed [DW-1:0] y_q, y_d;
  logic signed [ZW-1:0] z_q, z_d;
  logic [3:0]           iter_q, iter_d;
  logic                 run_q, run_d;
  logic                 neg_q, neg_d;

  logic [ANGLE_W+15:0]  w_prod;
  logic signed [DW-1:0] w_x0;
  logic signed [DW-1:0] w_xs;
  logic signed [DW-1:0] w_ys;
  logic signed [ZW-1:0] w_atan;

  // (length * K) >> 14 keeps 2 fractional bits of the Q0.16 product.
  assign w_prod = {16'b0, length} * {13'b0, CORDIC_K};
  assign w_x0   = DW'(w_prod >> 14);

  assign w_xs   = x_q >>> iter_q;
  assign w_ys   = y_q >>> iter_q;
  assign w_atan = $signed(atan_lut(iter_q));

  assign done = run_q && (iter_q == 4'(ITER - 1));
  assign x    = neg_q ? -x_q : x_q;
  assign y    = neg_q ? -y_q : y_q;

  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    z_d    = z_q;
    iter_d = iter_q;
    run_d  = run_q;
    neg_d  = neg_q;
    if (start) begin
      x_d    = w_x0;
      y_d    = '0;
      z_d    = angle;
      iter_d = '0;
      run_d  = 1'b1;
      neg_d  = negate;
    end else if (run_q) begin
      // d = +1 for z >= 0, -1 otherwise; all updates use the old x/y/z.
      if (z_q[ZW-1]) begin
        x_d = x_q + w_ys;
        y_d = y_q - w_xs;
        z_d = z_q + w_atan;
      end else begin
        x_d = x_q - w_ys;
        y_d = y_q + w_xs;
        z_d = z_q - w_atan;
      end
      iter_d = iter_q + 4'd1;
      if (done) begin
        run_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q    <= '0;
      y_q    <= '0;
      z_q    <= '0;
      iter_q <= '0;
      run_q  <= 1'b0;
      neg_q  <= 1'b0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      z_q    <= z_d;
      iter_q <= iter_d;
      run_q  <= run_d;
      neg_q  <= neg_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/forward_kinematics.sv
`default_nettype none
// ============================================================================
// Module      : forward_kinematics
// Description : SCARA forward kinematics, x = l1 cos th1 + l2 cos(th1+th2),
//               y = l1 sin th1 + l2 sin(th1+th2), using one shared iterative
//               CORDIC for both link rotations. Latency 36 cycles.
// Ports       : clk, reset        - clock, synchronous active-high reset
//               enable            - start request, sampled only when idle
//               th1, th2 [12:0]   - signed joint angles, LSB = 2*pi/8192
//               l1, l2   [12:0]   - unsigned link lengths
//               busy              - conversion in progress
//               dataReady         - result valid, held until next accept
//               xPos, yPos [14:0] - signed saturated end-effector position
// Revision    : 1.0 - initial release
// ============================================================================
module forward_kinematics
  import kinematics_pkg::*;
#(
  parameter int ITER = 16,
  parameter int DW   = 20
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic signed [ANGLE_W-1:0] th1,
  input  logic signed [ANGLE_W-1:0] th2,
  input  logic [ANGLE_W-1:0]        l1,
  input  logic [ANGLE_W-1:0]        l2,
  output logic                      busy,
  output logic                      dataReady,
  output logic signed [14:0]        xPos,
  output logic signed [14:0]        yPos
);

  localparam logic signed [DW-1:0] c_rnd     = DW'(2);
  localparam logic signed [DW-1:0] c_sat_max = DW'(16383);
  localparam logic signed [DW-1:0] c_sat_min = DW'(-16384);

  fk_state_t state_q, state_d;

  logic signed [ANGLE_W-1:0] th1_q, th1_d, th2_q, th2_d;
  logic [ANGLE_W-1:0]        l1_q, l1_d, l2_q, l2_d;
  logic [ANGLE_W-1:0]        ang1_q, ang1_d, ang2_q, ang2_d;
  logic                      neg1_q, neg1_d, neg2_q, neg2_d;
  logic                      rot_run_q, rot_run_d;
  logic signed [DW-1:0]      x1_q, x1_d, y1_q, y1_d;
  logic                      busy_q, busy_d, ready_q, ready_d;
  logic signed [14:0]        xpos_q, xpos_d, ypos_q, ypos_d;

  logic                      w_rot2;
  logic                      w_start;
  logic                      w_done;
  logic [ANGLE_W-1:0]        w_len;
  logic signed [ZW-1:0]      w_angle;
  logic                      w_negate;
  logic signed [DW-1:0]      w_cx, w_cy;
  logic signed [ANGLE_W-1:0] w_phi2;
  logic signed [DW-1:0]      w_sum_x, w_sum_y;

  function automatic logic signed [14:0] sat15(input logic signed [DW-1:0] v);
    if (v > c_sat_max) return 15'sh3FFF;
    if (v < c_sat_min) return 15'sh4000;
    return v[14:0];
  endfunction

  // One CORDIC serves both rotations; state selects which link feeds it.
  assign w_rot2   = (state_q == ST_ROT2);
  assign w_len    = w_rot2 ? l2_q : l1_q;
  assign w_angle  = $signed(w_rot2 ? {ang2_q, 3'b000} : {ang1_q, 3'b000});
  assign w_negate = w_rot2 ? neg2_q : neg1_q;
  // Load on the first cycle of each rotation state.
  assign w_start  = (state_q == ST_ROT1 || state_q == ST_ROT2) && !rot_run_q;

  // 13-bit sum wraps modulo 2*pi.
  assign w_phi2   = th1_q + th2_q;

  // Add 2 then >>> 2: round-half-up away the 2 fractional bits.
  assign w_sum_x  = (x1_q + w_cx + c_rnd) >>> 2;
  assign w_sum_y  = (y1_q + w_cy + c_rnd) >>> 2;

  cordic_rotate #(
    .ITER (ITER),
    .DW   (DW)
  ) u_cordic (
    .clk    (clk),
    .reset  (reset),
    .start  (w_start),
    .length (w_len),
    .angle  (w_angle),
    .negate (w_negate),
    .x      (w_cx),
    .y      (w_cy),
    .done   (w_done)
  );

  always_comb begin
    state_d   = state_q;
    th1_d     = th1_q;
    th2_d     = th2_q;
    l1_d      = l1_q;
    l2_d      = l2_q;
    ang1_d    = ang1_q;
    ang2_d    = ang2_q;
    neg1_d    = neg1_q;
    neg2_d    = neg2_q;
    x1_d      = x1_q;
    y1_d      = y1_q;
    busy_d    = busy_q;
    ready_d   = ready_q;
    xpos_d    = xpos_q;
    ypos_d    = ypos_q;
    rot_run_d = w_start ? 1'b1 : (w_done ? 1'b0 : rot_run_q);

    case (state_q)
      ST_INIT: begin
        if (enable) begin
          th1_d   = th1;
          th2_d   = th2;
          l1_d    = l1;
          l2_d    = l2;
          busy_d  = 1'b1;
          ready_d = 1'b0;
          state_d = ST_PREP;
        end
      end
      ST_PREP: begin
        {neg1_d, ang1_d} = quad_fold(th1_q);
        {neg2_d, ang2_d} = quad_fold(w_phi2);
        state_d = ST_ROT1;
      end
      ST_ROT1: begin
        if (w_done) state_d = ST_ROT2;
      end
      ST_ROT2: begin
        // The first rotation's result is still on the CORDIC outputs
        // during the cycle that loads the second rotation.
        if (w_start) begin
          x1_d = w_cx;
          y1_d = w_cy;
        end
        if (w_done) state_d = ST_SUM;
      end
      ST_SUM: begin
        xpos_d  = sat15(w_sum_x);
        ypos_d  = sat15(w_sum_y);
        ready_d = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_INIT;
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_INIT;
      th1_q     <= '0;
      th2_q     <= '0;
      l1_q      <= '0;
      l2_q      <= '0;
      ang1_q    <= '0;
      ang2_q    <= '0;
      neg1_q    <= 1'b0;
      neg2_q    <= 1'b0;
      rot_run_q <= 1'b0;
      x1_q      <= '0;
      y1_q      <= '0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b0;
      xpos_q    <= '0;
      ypos_q    <= '0;
    end else begin
      state_q   <= state_d;
      th1_q     <= th1_d;
      th2_q     <= th2_d;
      l1_q      <= l1_d;
      l2_q      <= l2_d;
      ang1_q    <= ang1_d;
      ang2_q    <= ang2_d;
      neg1_q    <= neg1_d;
      neg2_q    <= neg2_d;
      rot_run_q <= rot_run_d;
      x1_q      <= x1_d;
      y1_q      <= y1_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
      xpos_q    <= xpos_d;
      ypos_q    <= ypos_d;
    end
  end

  assign busy      = busy_q;
  assign dataReady = ready_q;
  assign xPos      = xpos_q;
  assign yPos      = ypos_q;

endmodule
`default_nettype wire

// File: tb/tb_forward_kinematics.sv
`default_nettype none
// ============================================================================
// Module      : tb_forward_kinematics
// Description : Directed and random stimulus for forward_kinematics with a
//               queue of expected positions from a real-valued model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_forward_kinematics;

  localparam real c_pi  = 3.14159265358979;
  localparam int  c_tol = 3;

  logic               clk = 1'b0;
  logic               reset;
  logic               enable;
  logic signed [12:0] th1, th2;
  logic [12:0]        l1, l2;
  logic               busy, dataReady;
  logic signed [14:0] xPos, yPos;

  typedef struct {
    int x;
    int y;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   last_x = 0;
  int   last_y = 0;

  forward_kinematics #(.ITER(16), .DW(20)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .th1       (th1),
    .th2       (th2),
    .l1        (l1),
    .l2        (l2),
    .busy      (busy),
    .dataReady (dataReady),
    .xPos      (xPos),
    .yPos      (yPos)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_near(input string tag, input int obs, input int exp);
    int diff;
    diff = obs - exp;
    if (diff < 0) diff = -diff;
    n_vec++;
    assert (diff <= c_tol) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d (+/-%0d)", tag, obs, exp, c_tol);
    end
  endtask

  function automatic int model(input int a1, input int a2, input int ln1,
                               input int ln2, input bit is_y);
    real u, v;
    int  r;
    u = 2.0 * c_pi / 8192.0;
    if (is_y) v = ln1 * $sin(a1 * u) + ln2 * $sin((a1 + a2) * u);
    else      v = ln1 * $cos(a1 * u) + ln2 * $cos((a1 + a2) * u);
    r = $rtoi($floor(v + 0.5));
    if (r > 16383)  r = 16383;
    if (r < -16384) r = -16384;
    return r;
  endfunction

  // Starts at a negedge, returns at a negedge. 'pulse' re-pulses enable and
  // scrambles the inputs mid-conversion; 'rst_mid' aborts with reset.
  task automatic run_conv(input int a1, input int a2, input int ln1, input int ln2,
                          input bit pulse, input bit rst_mid);
    exp_t e;
    int   cyc;
    bit   busy_ok;
    th1 = 13'(a1);
    th2 = 13'(a2);
    l1  = 13'(ln1);
    l2  = 13'(ln2);
    enable = 1'b1;
    @(negedge clk);              // accept edge has passed
    enable = 1'b0;
    e.x = model(a1, a2, ln1, ln2, 1'b0);
    e.y = model(a1, a2, ln1, ln2, 1'b1);
    sb.push_back(e);
    cyc = 0;
    busy_ok = 1'b1;
    while (dataReady !== 1'b1 && cyc < 60) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (cyc == 18) begin
        chk_near("hold_x", int'(xPos), last_x);
        chk_near("hold_y", int'(yPos), last_y);
      end
      if (pulse) begin
        enable = (cyc == 4 || cyc == 19);
        if (cyc == 0) begin
          th1 = th1 + 13'sd1500;
          th2 = -th2;
          l1  = 13'd100;
          l2  = 13'd7000;
        end
      end
      if (rst_mid && cyc == 9) reset = 1'b1;
      @(negedge clk);
      cyc++;
      if (rst_mid && cyc == 10) begin
        chk_eq("rst_busy",  int'(busy), 0);
        chk_eq("rst_ready", int'(dataReady), 0);
        chk_eq("rst_x",     int'(xPos), 0);
        chk_eq("rst_y",     int'(yPos), 0);
        reset = 1'b0;
        sb.delete();
        last_x = 0;
        last_y = 0;
        @(negedge clk);
        return;
      end
    end
    enable = 1'b0;
    chk_eq("latency",     cyc, 36);
    chk_eq("busy_during", int'(busy_ok), 1);
    chk_eq("busy_after",  int'(busy), 0);
    chk_eq("ready",       int'(dataReady), 1);
    chk_eq("sb_depth",    sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk_near("x", int'(xPos), e.x);
      chk_near("y", int'(yPos), e.y);
      last_x = e.x;
      last_y = e.y;
    end
  endtask

  initial begin
    int r1, r2;
    reset  = 1'b1;
    enable = 1'b0;
    th1 = '0; th2 = '0; l1 = '0; l2 = '0;
    repeat (3) @(negedge clk);
    chk_eq("reset_busy",  int'(busy), 0);
    chk_eq("reset_ready", int'(dataReady), 0);
    chk_eq("reset_x",     int'(xPos), 0);
    chk_eq("reset_y",     int'(yPos), 0);
    reset = 1'b0;
    @(negedge clk);

    run_conv(0,     0,    4000, 4000, 1'b0, 1'b0);
    run_conv(2048,  0,    4000, 4000, 1'b0, 1'b0);
    run_conv(0,     2048, 4000, 4000, 1'b0, 1'b0);
    run_conv(-4096, 0,    4000, 4000, 1'b0, 1'b0);
    run_conv(4095,  4095, 4000, 4000, 1'b0, 1'b0);
    run_conv(1000,  500,  4000, 4000, 1'b0, 1'b1);
    run_conv(1000,  500,  4000, 4000, 1'b0, 1'b0);
    run_conv(1500,  -700, 4000, 4000, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      r1 = int'($urandom_range(8191)) - 4096;
      r2 = int'($urandom_range(8191)) - 4096;
      run_conv(r1, r2, 4000, 4000, 1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/forward_kinematics.md
# forward_kinematics

Computes the SCARA end-effector position (x, y) from joint angles th1, th2 and link lengths l1, l2: x = l1·cos th1 + l2·cos(th1+th2), y = l1·sin th1 + l2·sin(th1+th2). It is the inverse of the angle-calculation path. The motor/encoder side uses it to report the actual Cartesian position back to the host and to close the loop against commanded targets. The datapath is fixed-point with an iterative CORDIC, so it needs no floating-point IP.

## Interface
Parameters:
- ITER, 16: number of CORDIC iterations per rotation.
- DW, 20: internal signed datapath width, with 2 fractional bits.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- enable  in  1  start request; sampled only in Init.
- th1  in  13  signed joint-1 angle; LSB = 2π/8192, range [−π, π).
- th2  in  13  signed joint-2 angle; same format as th1.
- l1  in  13  unsigned link-1 length, in position LSBs.
- l2  in  13  unsigned link-2 length, in position LSBs.
- busy  out  1  high from the accept edge until dataReady rises.
- dataReady  out  1  result valid; held until the next accept.
- xPos  out  15  signed two's-complement x position.
- yPos  out  15  signed two's-complement y position.

## Operation
- Reset value of every output is 0. The FSM goes to Init.
- FSM states: Init → Prep → Rot1 → Rot2 → Sum → Init.
- **Init:** when enable=1, register th1/th2/l1/l2, clear dataReady, set busy. Go to Prep.
- **Prep:**
  - phi2 = th1 + th2, computed in 13 bits so it wraps modulo 2π.
  - Both angles are extended to a 16-bit internal angle by appending 3 zero LSBs.
  - Quadrant fold: if angle > +π/2 or angle < −π/2, add π (wrapping) and set a negate flag for that rotation. Angle −π folds to 0 with negate set.
- **Rot1 / Rot2:** the sub-module rotates the vector (l·K, 0) by the folded angle, for th1/l1 and then phi2/l2.
  - K = 39797 (0.607253 in Q0.16). Start x0 = (l·39797) >> 14.
  - Each iteration i: d = sign(z); x −= d·(y>>>i); y += d·(x>>>i); z −= d·atan[i]. All three updates use the previous-cycle values.
  - If the negate flag is set, negate both results.
- **Sum:**
  - X = x1 + x2 and Y = y1 + y2, in DW bits.
  - Round: add 2, then arithmetic shift right by 2.
  - Saturate to [−16384, 16383] and register into xPos/yPos.
  - Set dataReady=1 and busy=0, then return to Init.
- enable while busy is ignored. Inputs may change freely after the accept edge.
- Reset asserted in any state: the next edge forces Init, clears all outputs, and discards the partial result.
- Accuracy: |error| ≤ 3 LSB per axis over the full input range.

## Timing
- Edge 0 samples enable in Init.
- Prep occupies edge 1.
- Rot1 occupies edges 2–18: 1 load plus 16 iterations.
- Rot2 occupies edges 19–35.
- Sum occupies edge 36. xPos, yPos and dataReady are valid after edge 36, a latency of 36 cycles.
- Back-to-back use: enable held high is accepted on the first Init cycle after dataReady rises. Minimum period is 37 cycles.
- xPos/yPos change only on the Sum edge or on reset.

## Structure
- Package kinematics_pkg contains:
  - the FSM state typedef;
  - ANGLE_W = 13;
  - the CORDIC gain constant 39797;
  - the 16-entry atan table in 16-bit angle units: 8192, 4836, 2555, 1297, 651, 326, 163, 81, 41, 20, 10, 5, 3, 1, 1, 0;
  - the π/2 and π constants: 2048 and 4096 in 13-bit units.
- One sub-module, cordic_rotate:
  - inputs: start, length, angle, negate;
  - outputs: x, y, done;
  - iterative with one iteration per clock;
  - shared by Rot1 and Rot2, with its inputs muxed by state.

## Test plan
All cases use l1 = l2 = 4000, tolerance ±3 LSB.
- th1=0, th2=0 → xPos=8000, yPos=0; dataReady exactly 36 cycles after accept; busy high for those 36 cycles.
- th1=2048 (90°), th2=0 → xPos=0, yPos=8000.
- th1=0, th2=2048 → xPos=4000, yPos=4000. Then th1=−4096, th2=0 → xPos=−8000, yPos=0, which exercises the −π fold and negation.
- th1=4095, th2=4095 (phi2 wraps to −2) → xPos=0, yPos=−3. Also sweep random angles against a real-valued model.
- Reset asserted at cycle 10 of a conversion → all outputs 0 on the next edge. A fresh enable then yields the correct result in 36 cycles.
- enable pulsed at cycles 5 and 20 mid-conversion, with inputs changed after accept → ignored; the result reflects the originally sampled inputs.
